load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data memory interface.
- Accepts one RISC-V load/store request at a time from the CPU execute/mem stage and drives the word-only data memory port (address, write enable, write data, combinational read data).
- Loads: performs byte/halfword lane extraction with sign or zero extension.
- Sub-word stores: performed as a read-modify-write, because the memory only writes whole words.
- Reports misaligned or illegal accesses as errors.

Parameters:
- DATA_WIDTH, 32, data word width (only 32 supported).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present; sampled only while req_ready=1
- req_ready  output  1  high only in IDLE
- req_is_store  input  1  1=store, 0=load
- req_funct3  input  3  RISC-V funct3 (size/sign)
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data; low bits used for SB/SH
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  DATA_WIDTH  extended load result; 0 for stores/errors
- resp_err  output  1  misaligned or illegal funct3, valid with resp_valid
- mem_addr  output  ADDR_WIDTH  word-aligned address to data memory
- mem_wr_en  output  1  memory write strobe
- mem_wr_data  output  DATA_WIDTH  full word to write
- mem_rd_data  input  DATA_WIDTH  combinational read data; valid when mem_wr_en=0

Behaviour:
- Request latching: on acceptance (req_valid & req_ready), latch is_store, funct3, addr and wdata. Later changes on req_* are ignored until IDLE returns.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other encoding is an error.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=00. B is always aligned.
- Memory addressing: mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00} whenever the FSM is not IDLE/RESP; otherwise 0. mem_wr_en=1 only in ST_WR. mem_wr_data is 0 outside ST_WR.
- Lanes are little-endian:
  - byte k = word[8k+7:8k], k=addr[1:0].
  - halfword at addr[1]: word[16*addr[1]+15 : 16*addr[1]].
- States:
  - IDLE: req_ready=1. On accept:
    - error → RESP;
    - load → LD;
    - SW → ST_WR;
    - SB/SH → ST_RD.
  - LD: capture the extracted, extended lane from mem_rd_data into resp_rdata → RESP.
  - ST_RD: capture the merged word into an internal register → ST_WR. The merged word is mem_rd_data with the selected byte/halfword lane replaced by req_wdata[7:0] or req_wdata[15:0].
  - ST_WR: mem_wr_en=1; mem_wr_data = merged word (SW: latched wdata) → RESP.
  - RESP: resp_valid=1 for exactly one cycle; resp_err set per the checks above → IDLE.
- resp_rdata and resp_err are held until the next acceptance; they are cleared to 0 on accept.
- Latency, accept cycle T to resp_valid cycle:
  - load: T+2;
  - SW: T+2;
  - SB/SH: T+3;
  - error: T+1.
- Back-to-back: a new request can be accepted the cycle after RESP (IDLE); there is no pipelining.
- Error requests never assert mem_wr_en and never change memory.
- Reset:
  - outputs: req_ready=0 during the rst cycle, then 1; resp_valid=0, resp_rdata=0, resp_err=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0;
  - state → IDLE.
  - Reset during ST_RD aborts the store with no write. Reset in the same cycle as ST_WR suppresses the write; rst has priority.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: alignment checks as above; misaligned access → error response, no memory access.
- Undefined:
  - no alignment check; the lane offset is forced aligned (H uses addr[1] only, W ignores addr[1:0]);
  - the access proceeds normally;
  - resp_err is raised only for illegal funct3.

Test Plan:
- Preload word 0x02000010 = 0x8899AABB; LB addr 0x02000011 → resp_valid at T+2, resp_rdata=0xFFFFFFAA, resp_err=0; LBU same addr → 0x000000AA.
- Same word; SB addr 0x02000012, wdata 0x12345677 → ST_RD then ST_WR with mem_wr_data=0x8877AABB at T+2; subsequent LW → 0x8877AABB.
- SH addr 0x02000012, wdata 0x0000CAFE on word 0x8899AABB → mem_wr_data=0xCAFEAABB; LH addr 0x02000012 → 0xFFFFCAFE; LHU → 0x0000CAFE.
- LW addr 0x02000006 (macro defined) → resp_valid at T+1, resp_err=1, resp_rdata=0, mem_wr_en never 1; illegal load funct3=011 → same error response.
- Assert rst in ST_RD of SB to 0x02000020 → no mem_wr_en pulse, memory word unchanged, outputs 0, req_ready=1 the cycle after rst drops.
- Back-to-back SW 0x02000030 = 0xDEADBEEF then LW same addr, req_valid held high → second accepted in the cycle after the first resp_valid, returns 0xDEADBEEF.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time RISC-V load/store initiator for a word-only data memory.
// Optional macro LSU_MISALIGN_CHECK_EN turns misaligned halfword/word accesses into error responses.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD    = 3'd1,
        S_ST_RD = 3'd2,
        S_ST_WR = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_merged;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  w_accept;
    logic                  w_legal;
    logic                  w_misalign;
    logic                  w_err;

    // Halfword lane selection only looks at off[1], so an unchecked odd address lands on its aligned halfword.
    function automatic logic [DATA_WIDTH-1:0] f_extract(input logic [DATA_WIDTH-1:0] word,
                                                         input logic [2:0] f3, input logic [1:0] off);
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] res;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  res = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b001:  res = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b100:  res = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b101:  res = {{(DATA_WIDTH-16){1'b0}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_merge(input logic [DATA_WIDTH-1:0] word,
                                                       input logic [DATA_WIDTH-1:0] wd,
                                                       input logic [2:0] f3, input logic [1:0] off);
        logic [DATA_WIDTH-1:0] res;
        res = word;
        case (f3)
            3'b000:  res[{off, 3'b000} +: 8] = wd[7:0];
            3'b001:  res[{off[1], 4'b0000} +: 16] = wd[15:0];
            default: res = wd;
        endcase
        return res;
    endfunction

    assign w_accept = req_valid && req_ready;
    assign w_err    = !w_legal || w_misalign;

    // funct3 legality for the incoming request
    always_comb begin
        w_legal = 1'b0;
        if (req_is_store) begin
            w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                default:                                w_legal = 1'b0;
            endcase
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    // Alignment check for the incoming request
    always_comb begin
        case (req_funct3[1:0])
            2'b01:   w_misalign = req_addr[0];
            2'b10:   w_misalign = |req_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_accept) begin
                    w_next = S_IDLE;
                end else if (w_err) begin
                    w_next = S_RESP;
                end else if (!req_is_store) begin
                    w_next = S_LD;
                end else if (req_funct3 == 3'b010) begin
                    w_next = S_ST_WR;
                end else begin
                    w_next = S_ST_RD;
                end
            end
            S_LD:    w_next = S_RESP;
            S_ST_RD: w_next = S_ST_WR;
            S_ST_WR: w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, request latch, merged store word and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_merged <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_merged <= req_wdata;
                r_rdata  <= '0;
                r_err    <= w_err;
            end else if (r_state == S_LD) begin
                r_rdata <= f_extract(mem_rd_data, r_funct3, r_addr[1:0]);
            end else if (r_state == S_ST_RD) begin
                r_merged <= f_merge(mem_rd_data, r_wdata, r_funct3, r_addr[1:0]);
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

    // rst gates the handshake and memory strobes so a reset landing on ST_WR never writes
    assign req_ready   = (r_state == S_IDLE) && !rst;
    assign resp_valid  = (r_state == S_RESP) && !rst;
    assign resp_rdata  = r_rdata;
    assign resp_err    = r_err;
    assign mem_wr_en   = (r_state == S_ST_WR) && !rst;
    assign mem_wr_data = mem_wr_en ? r_merged : '0;
    assign mem_addr    = (!rst && (r_state inside {S_LD, S_ST_RD, S_ST_WR}))
                         ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-addressed reference memory, directed plan cases, random traffic.
module tb_load_store_unit;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    logic [31:0] dmem [0:63];
    logic [7:0]  rbyte [0:255];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'd0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    always_comb begin
        if (mem_addr[31:8] == BASE[31:8]) mem_rd_data = dmem[mem_addr[7:2]];
        else mem_rd_data = 32'h0BAD_0BAD;
    end

    always @(posedge clk) begin
        if (pl_en) dmem[pl_idx] <= pl_val;
        else if (mem_wr_en && (mem_addr[31:8] == BASE[31:8])) dmem[mem_addr[7:2]] <= mem_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int unsigned wi);
        return {rbyte[wi*4+3], rbyte[wi*4+2], rbyte[wi*4+1], rbyte[wi*4]};
    endfunction

    task automatic preload(input int unsigned wi, input logic [31:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = wi[5:0]; pl_val = v;
        for (int b = 0; b < 4; b++) rbyte[wi*4+b] = v[8*b +: 8];
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // One request: expectations come from the byte-level reference memory, then the DUT is driven and compared.
    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int unsigned sz, off;
        int          lat, exp_lat, wr_cnt;
        logic        legal, err;
        logic [31:0] ea, exp_rd, exp_wr, got_wr, got_waddr, rnd;
        sz = 1 << f3[1:0];
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err = !legal;
`ifdef LSU_MISALIGN_CHECK_EN
        if (legal && ((a % sz) != 0)) err = 1'b1;
        ea = a;
`else
        ea = a - (a % sz);
`endif
        off = ea - BASE;
        exp_rd = 32'd0;
        exp_wr = 32'd0;
        if (!st && !err) begin
            for (int i = 0; i < int'(sz); i++) exp_rd[8*i +: 8] = rbyte[off+i];
            if (sz < 4 && !f3[2] && exp_rd[8*sz-1])
                for (int i = 8*sz; i < 32; i++) exp_rd[i] = 1'b1;
        end
        if (st && !err) begin
            for (int i = 0; i < int'(sz); i++) rbyte[off+i] = wd[8*i +: 8];
            exp_wr = ref_word(off / 4);
        end
        exp_lat = err ? 1 : ((!st || sz == 4) ? 2 : 3);

        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        chk1("req_ready_before_accept", req_ready, 1'b1);
        @(negedge clk);
        rnd = $urandom;
        req_valid = 1'b0; req_is_store = rnd[0]; req_funct3 = rnd[3:1];
        req_addr = $urandom; req_wdata = $urandom;
        lat = 1; wr_cnt = 0; got_wr = 32'd0; got_waddr = 32'd0;
        while (!resp_valid && lat < 8) begin
            if (mem_wr_en) begin wr_cnt++; got_wr = mem_wr_data; got_waddr = mem_addr; end
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk1("resp_err", resp_err, err);
        chk("write_count", wr_cnt, (st && !err) ? 1 : 0);
        if (st && !err) begin
            chk("mem_wr_data", got_wr, exp_wr);
            chk("mem_wr_addr", got_waddr, BASE + (off & 32'hFFFF_FFFC));
        end
        @(negedge clk);
        chk1("resp_valid_one_cycle", resp_valid, 1'b0);
        chk1("ready_after_resp", req_ready, 1'b1);
        chk("rdata_held", resp_rdata, exp_rd);
    endtask

    initial begin
        logic [31:0] rnd;
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        for (int w = 0; w < 64; w++) preload(w, $urandom);
        chk1("rst_ready", req_ready, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk1("rst_err", resp_err, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk1("rst_wr_en", mem_wr_en, 1'b0);
        chk("rst_wr_data", mem_wr_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk1("ready_after_rst", req_ready, 1'b1);

        // Byte loads, sign and zero extended
        preload(4, 32'h8899_AABB);
        run_req(1'b0, 3'b000, BASE + 32'h11, 32'd0);
        chk("lb_value", resp_rdata, 32'hFFFF_FFAA);
        run_req(1'b0, 3'b100, BASE + 32'h11, 32'd0);
        chk("lbu_value", resp_rdata, 32'h0000_00AA);
        // Read-modify-write byte store then word readback
        run_req(1'b1, 3'b000, BASE + 32'h12, 32'h1234_5677);
        run_req(1'b0, 3'b010, BASE + 32'h10, 32'd0);
        chk("lw_after_sb", resp_rdata, 32'h8877_AABB);
        // Halfword store and loads
        preload(4, 32'h8899_AABB);
        run_req(1'b1, 3'b001, BASE + 32'h12, 32'h0000_CAFE);
        chk("sh_mem_word", dmem[4], 32'hCAFE_AABB);
        run_req(1'b0, 3'b001, BASE + 32'h12, 32'd0);
        chk("lh_value", resp_rdata, 32'hFFFF_CAFE);
        run_req(1'b0, 3'b101, BASE + 32'h12, 32'd0);
        chk("lhu_value", resp_rdata, 32'h0000_CAFE);
        // Misaligned word and illegal funct3
        run_req(1'b0, 3'b010, BASE + 32'h06, 32'd0);
        run_req(1'b0, 3'b011, BASE + 32'h08, 32'd0);
        chk1("illegal_ld_err", resp_err, 1'b1);
        run_req(1'b1, 3'b100, BASE + 32'h08, 32'h5555_5555);
        chk1("illegal_st_err", resp_err, 1'b1);

        // Reset while the byte store sits in its read phase
        run_req(1'b0, 3'b010, BASE + 32'h10, 32'd0);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
        req_addr = BASE + 32'h20; req_wdata = 32'h0000_00A5;
        @(negedge clk);
        req_valid = 1'b0;
        chk1("strd_no_write", mem_wr_en, 1'b0);
        chk("strd_mem_addr", mem_addr, BASE + 32'h20);
        rst = 1'b1;
        @(negedge clk);
        chk1("abort_wr_en", mem_wr_en, 1'b0);
        chk1("abort_ready_in_rst", req_ready, 1'b0);
        chk1("abort_resp_valid", resp_valid, 1'b0);
        chk("abort_rdata", resp_rdata, 32'd0);
        chk1("abort_err", resp_err, 1'b0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_wr_data", mem_wr_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk1("abort_ready_after", req_ready, 1'b1);
        chk1("abort_wr_en_after", mem_wr_en, 1'b0);
        chk("abort_mem_unchanged", dmem[8], ref_word(8));

        // Back-to-back SW then LW with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
        req_addr = BASE + 32'h30; req_wdata = 32'hDEAD_BEEF;
        for (int b = 0; b < 4; b++) rbyte[48+b] = req_wdata[8*b +: 8];
        @(negedge clk);
        chk1("b2b_sw_wr_en", mem_wr_en, 1'b1);
        chk("b2b_sw_wr_data", mem_wr_data, 32'hDEAD_BEEF);
        req_is_store = 1'b0; req_wdata = 32'd0;
        @(negedge clk);
        chk1("b2b_sw_resp", resp_valid, 1'b1);
        chk1("b2b_busy_ready", req_ready, 1'b0);
        @(negedge clk);
        chk1("b2b_accept_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chk1("b2b_ld_pending", resp_valid, 1'b0);
        @(negedge clk);
        chk1("b2b_lw_resp", resp_valid, 1'b1);
        chk("b2b_lw_rdata", resp_rdata, ref_word(12));
        chk1("b2b_lw_err", resp_err, 1'b0);

        // Random traffic inside a 256-byte window
        for (int n = 0; n < 200; n++) begin
            rnd = $urandom;
            run_req(rnd[0], rnd[3:1], BASE + {24'd0, rnd[11:4]}, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
